// File: rtl/sap_ctrl_pkg.sv
// sap_ctrl_pkg: shared opcodes, FSM state encoding and control-word type
// for the accumulator-datapath control sequencer.
package sap_ctrl_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LDA   = 3'd1;
  localparam logic [2:0] OP_LDB   = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_OUTA  = 3'd5;
  localparam logic [2:0] OP_CMP   = 3'd6;
  localparam logic [2:0] OP_MOVAB = 3'd7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Settle counter width; holds SETTLE_CYCLES-1 for the legal range 1..15.
  localparam int SETTLE_CNT_W = 4;

  typedef struct packed {
    logic nLa;
    logic nLb;
    logic Ea;
    logic Eb;
    logic Eu;
    logic sub;
    logic Ei;
  } ctrl_word_t;

  // Loads are active-low, so the idle word has both load bits high.
  localparam ctrl_word_t CTRL_INACTIVE = '{
    nLa: 1'b1, nLb: 1'b1, Ea: 1'b0, Eb: 1'b0, Eu: 1'b0, sub: 1'b0, Ei: 1'b0
  };

  // Opcodes whose result flags are worth keeping.
  function automatic logic is_flag_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// sap_control_sequencer_if: opcode handshake, flag inputs and control-word
// outputs between the sequencer (master) and datapath/issuer (slave).
interface sap_control_sequencer_if #(
  parameter int OPCODE_W = 3
);
  logic [OPCODE_W-1:0] instr_op;
  logic                instr_valid;
  logic                instr_ready;
  logic                cf_in;
  logic                zf_in;
  logic                nLa;
  logic                nLb;
  logic                Ea;
  logic                Eb;
  logic                Eu;
  logic                sub;
  logic                Ei;
  logic                out_strobe;
  logic                done;
  logic [1:0]          flags_q;

  modport master (
    input  instr_op, instr_valid, cf_in, zf_in,
    output instr_ready, nLa, nLb, Ea, Eb, Eu, sub, Ei, out_strobe, done, flags_q
  );

  modport slave (
    output instr_op, instr_valid, cf_in, zf_in,
    input  instr_ready, nLa, nLb, Ea, Eb, Eu, sub, Ei, out_strobe, done, flags_q
  );
endinterface

// File: rtl/sap_ctrl_decode.sv
// sap_ctrl_decode: combinational opcode decode into bus-driver fields
// (loads left inactive), which register to load, and the OUTA marker.
module sap_ctrl_decode
  import sap_ctrl_pkg::*;
(
  input  logic [2:0] op,
  output ctrl_word_t drive_word,
  output logic       load_a,
  output logic       load_b,
  output logic       out_a,
  output logic       flag_op
);

  // One driver per opcode at most; Eb is never selected.
  always_comb begin
    drive_word = CTRL_INACTIVE;
    load_a     = 1'b0;
    load_b     = 1'b0;
    out_a      = 1'b0;
    flag_op    = is_flag_op(op);
    case (op)
      OP_LDA:   begin drive_word.Ei = 1'b1; load_a = 1'b1; end
      OP_LDB:   begin drive_word.Ei = 1'b1; load_b = 1'b1; end
      OP_ADD:   begin drive_word.Eu = 1'b1; load_a = 1'b1; end
      OP_SUB:   begin drive_word.Eu = 1'b1; drive_word.sub = 1'b1; load_a = 1'b1; end
      OP_OUTA:  begin drive_word.Ea = 1'b1; out_a = 1'b1; end
      OP_CMP:   begin drive_word.Eu = 1'b1; drive_word.sub = 1'b1; end
      OP_MOVAB: begin drive_word.Ea = 1'b1; load_b = 1'b1; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: accepts one opcode per valid/ready handshake and
// emits a registered control word: drivers settle for SETTLE_CYCLES
// (legal 1..15) before a one-cycle load strobe, then a done pulse.
// Optional flag capture on ADD/SUB/CMP is built with SEQ_FLAG_CAPTURE_EN.
//
// state  | meaning
// IDLE   | ready high, control word inactive, waiting for an opcode
// SETTLE | drivers on, loads off, settle counter running down
// LOAD   | drivers held, load strobe (or out_strobe) was just issued
// DONE   | control word inactive, done pulse issued, ready still low
module sap_control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int OPCODE_W      = 3
)
(
  input  logic                     clk,
  input  logic                     rst,
  sap_control_sequencer_if.master  bus
);

  logic [1:0]              state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [OPCODE_W-1:0]     op_q, op_d;
  ctrl_word_t              ctrl_q, ctrl_d;
  logic                    ready_q, ready_d;
  logic                    out_q, out_d;
  logic                    done_q, done_d;

  logic [2:0]              dec_op;
  ctrl_word_t              dec_word;
  logic                    dec_load_a;
  logic                    dec_load_b;
  logic                    dec_out_a;
  logic                    dec_flag_op;

  // Decode the incoming opcode while idle so drivers can rise on the accept edge.
  always_comb begin
    dec_op = (state_q == ST_IDLE) ? bus.instr_op[2:0] : op_q[2:0];
  end

  sap_ctrl_decode u_decode (
    .op         (dec_op),
    .drive_word (dec_word),
    .load_a     (dec_load_a),
    .load_b     (dec_load_b),
    .out_a      (dec_out_a),
    .flag_op    (dec_flag_op)
  );

  // Next-state and next control word; outputs are registered from these.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ctrl_d  = CTRL_INACTIVE;
    ready_d = ready_q;
    out_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.instr_valid && ready_q) begin
          op_d    = bus.instr_op;
          ctrl_d  = dec_word;
          cnt_d   = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
          ready_d = 1'b0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        ctrl_d = dec_word;
        if (cnt_q == '0) begin
          ctrl_d.nLa = ~dec_load_a;
          ctrl_d.nLb = ~dec_load_b;
          out_d      = dec_out_a;
          state_d    = ST_LOAD;
        end else begin
          cnt_d = cnt_q - SETTLE_CNT_W'(1);
        end
      end
      ST_LOAD: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight strobe at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ctrl_q  <= CTRL_INACTIVE;
      ready_q <= 1'b1;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.nLa         = ctrl_q.nLa;
  assign bus.nLb         = ctrl_q.nLb;
  assign bus.Ea          = ctrl_q.Ea;
  assign bus.Eb          = ctrl_q.Eb;
  assign bus.Eu          = ctrl_q.Eu;
  assign bus.sub         = ctrl_q.sub;
  assign bus.Ei          = ctrl_q.Ei;
  assign bus.out_strobe  = out_q;
  assign bus.done        = done_q;

`ifdef SEQ_FLAG_CAPTURE_EN
  logic [1:0] flags_q, flags_d;

  // Flags are taken while the done pulse is visible, so the ALU result has settled.
  always_comb begin
    flags_d = flags_q;
    if (state_q == ST_DONE && dec_flag_op) begin
      flags_d = {bus.cf_in, bus.zf_in};
    end
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 2'b00;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.flags_q = flags_q;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{bus.cf_in, bus.zf_in, dec_flag_op};
  assign bus.flags_q        = 2'b00;
`endif

endmodule
